// File: rtl/ob_pkg.sv
// Shared types for the order-book command path: command layout, frame sizing,
// and the opcode legality helper used by the ingress filter.
package ob_pkg;

  localparam int CMD_BYTES_N = 14;
  localparam int CMD_FRAME_W = CMD_BYTES_N * 8;

  typedef enum logic [3:0] {
    Op_Nop        = 4'h0,
    Op_BuyLimit   = 4'h1,
    Op_SellLimit  = 4'h2,
    Op_BuyMarket  = 4'h3,
    Op_SellMarket = 4'h4,
    Op_Cancel     = 4'h5,
    Op_Modify     = 4'h6,
    Op_Query      = 4'h8,
    Op_Halt       = 4'h9,
    Op_Resume     = 4'hA,
    Op_Flush      = 4'hB
  } opcode_t;

  typedef enum logic [2:0] {
    Tif_Day               = 3'd0,
    Tif_ImmediateOrCancel = 3'd1,
    Tif_FillOrKill        = 3'd2,
    Tif_AllOrNone         = 3'd3
  } tif_t;

  typedef struct packed {
    logic [31:0] uid;
    opcode_t     opcode;
    tif_t        tif;
    logic [19:0] price;
    logic [15:0] quantity;
    logic [31:0] uid1;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Legal opcodes are 0x0-0x6 and 0x8-0xB; 0x7 and 0xC-0xF are reserved.
  function automatic logic opcode_is_legal(opcode_t op);
    logic [3:0] v;
    v = op;
    return (v <= 4'h6) || ((v >= 4'h8) && (v <= 4'hB));
  endfunction

endpackage

// File: rtl/ob_cmd_filter.sv
// Combinational validity check on an assembled command. A command is rejected
// for a reserved opcode, the engine-reserved uid (all ones), or an unknown tif.
module ob_cmd_filter
  import ob_pkg::*;
(
  input  logic [31:0] uid,
  input  opcode_t     opcode,
  input  tif_t        tif,
  output logic        ok
);

  assign ok = opcode_is_legal(opcode) && (uid != '1) && (tif <= Tif_AllOrNone);

endmodule

// File: rtl/ob_cmd_des.sv
// Command ingress deserializer: collects 14-byte MSB-first frames into cmd_t
// and holds one command for the matching engine behind a valid/accept
// handshake. Define OB_CMD_DES_FILTER_EN to drop illegal commands and pulse
// err_filter_r instead of forwarding them.
module ob_cmd_des
  import ob_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  output logic       cmd_vld,
  output cmd_t       cmd_r,
  input  logic       cmd_accept,
  output logic       err_framing_r,
  output logic       err_filter_r
);

  localparam int         ASM_W = CMD_FRAME_W - 8;
  localparam logic [3:0] LAST  = 4'(CMD_BYTES_N - 1);

  typedef enum logic {Ph_Idle, Ph_Collect} phase_t;

  logic [3:0]       cnt_r, cnt_nxt;
  logic [ASM_W-1:0] asm_r;
  phase_t           phase;
  logic             take, shift_en, frame_done, framing_err;
  logic             load, drop;
  cmd_t             new_cmd;
  logic             pad_unused;

  assign phase = (cnt_r == 4'd0) ? Ph_Idle : Ph_Collect;

  // Only the final byte can stall, and only while a command is still held.
  assign in_rdy = (cnt_r != LAST) | !cmd_vld | cmd_accept;
  assign take   = in_vld & in_rdy;

  // Top padding bits of the frame never reach cmd_t.
  assign new_cmd    = cmd_t'({asm_r[CMD_W-9:0], in_data});
  assign pad_unused = ^asm_r[ASM_W-1:CMD_W-8];

  // Counter state register; the counter value is the FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_r <= '0;
    else        cnt_r <= cnt_nxt;
  end

  // Next-state and framing decisions for each accepted byte.
  always_comb begin
    cnt_nxt     = cnt_r;
    shift_en    = 1'b0;
    frame_done  = 1'b0;
    framing_err = 1'b0;
    if (take) begin
      case (phase)
        Ph_Idle: begin
          if (!in_sof) begin
            framing_err = 1'b1;
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = 4'd1;
          end
        end
        Ph_Collect: begin
          if (in_sof) begin
            // Restart: this byte becomes byte 0 of a fresh frame.
            framing_err = 1'b1;
            shift_en    = 1'b1;
            cnt_nxt     = 4'd1;
          end else if (cnt_r == LAST) begin
            frame_done = 1'b1;
            cnt_nxt    = 4'd0;
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = cnt_r + 4'd1;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

`ifdef OB_CMD_DES_FILTER_EN
  logic cmd_ok;

  ob_cmd_filter u_filter (
    .uid    (new_cmd.uid),
    .opcode (new_cmd.opcode),
    .tif    (new_cmd.tif),
    .ok     (cmd_ok)
  );

  assign load = frame_done & cmd_ok;
  assign drop = frame_done & !cmd_ok;

  // Filter error pulse, one cycle after the dropped frame's final byte.
  always_ff @(posedge clk) begin
    if (!rst_n) err_filter_r <= 1'b0;
    else        err_filter_r <= drop;
  end
`else
  assign load         = frame_done;
  assign drop         = 1'b0;
  assign err_filter_r = 1'b0;
`endif

  // Assembly shift register: bytes 0..12 of the frame, MSB first.
  always_ff @(posedge clk) begin
    if (!rst_n)        asm_r <= '0;
    else if (shift_en) asm_r <= {asm_r[ASM_W-9:0], in_data};
  end

  // Output register; a completing frame wins over accept so there is no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_vld <= 1'b0;
      cmd_r   <= '0;
    end else if (load) begin
      cmd_vld <= 1'b1;
      cmd_r   <= new_cmd;
    end else if (cmd_accept) begin
      cmd_vld <= 1'b0;
    end
  end

  // Framing error pulse, one cycle after the offending byte.
  always_ff @(posedge clk) begin
    if (!rst_n) err_framing_r <= 1'b0;
    else        err_framing_r <= framing_err;
  end

endmodule

// File: tb/tb_ob_cmd_des.sv
// Directed self-checking bench for ob_cmd_des. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_ob_cmd_des;
  import ob_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_rdy;
  logic       cmd_vld;
  cmd_t       cmd_r;
  logic       cmd_accept = 1'b0;
  logic       err_framing_r;
  logic       err_filter_r;

  int errors = 0;
  int checks = 0;

  // Monitor tallies (written only by the monitor process).
  int         deliv_n = 0;
  int         ferr_n  = 0;
  int         filt_n  = 0;
  logic [106:0] last_cmd = '0;

  always #5 clk = ~clk;

  ob_cmd_des dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_vld        (in_vld),
    .in_sof        (in_sof),
    .in_data       (in_data),
    .in_rdy        (in_rdy),
    .cmd_vld       (cmd_vld),
    .cmd_r         (cmd_r),
    .cmd_accept    (cmd_accept),
    .err_framing_r (err_framing_r),
    .err_filter_r  (err_filter_r)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_vld && cmd_accept) begin
        deliv_n++;
        last_cmd <= cmd_r;
      end
      if (err_framing_r) ferr_n++;
      if (err_filter_r)  filt_n++;
    end
  end

  function automatic logic [111:0] mk(input logic [31:0] uid, input logic [3:0] op,
                                      input logic [2:0] tif, input logic [19:0] price,
                                      input logic [15:0] qty, input logic [31:0] uid1);
    return {5'b0, uid, op, tif, price, qty, uid1};
  endfunction

  task automatic drive(input logic v, input logic sof, input logic [7:0] d);
    @(posedge clk); #1;
    in_vld = v; in_sof = sof; in_data = d;
  endtask

  // Sends bytes 0..n-1 of f, holding each until in_rdy (bounded).
  task automatic send_frame(input logic [111:0] f, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, f[111-8*i -: 8]);
      @(negedge clk);
      t = 0;
      while (!in_rdy && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_rdy) begin
        errors++;
        $display("FAIL send_timeout byte=%0d in_rdy=%b required 1", i, in_rdy);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", cmd_vld); end
    checks++; if (cmd_r !== '0) begin errors++; $display("FAIL reset_cmd got=%h exp=0", cmd_r); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", in_rdy); end
    checks++; if ({err_framing_r, err_filter_r} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {err_framing_r, err_filter_r}); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single;
    logic [111:0] f;
    logic [106:0] exp_c;
    f = mk(32'h10, Op_BuyLimit, 3'd0, 20'h00100, 16'h0064, 32'h0);
    exp_c = f[106:0];
    cmd_accept = 1'b1;
    send_frame(f, 14);
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld got=%b exp=0", cmd_vld); end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", cmd_vld); end
    checks++; if (cmd_r !== exp_c) begin errors++; $display("FAIL single_cmd got=%h exp=%h", cmd_r, exp_c); end
    checks++; if (cmd_r.price !== 20'h00100 || cmd_r.quantity !== 16'h0064) begin errors++; $display("FAIL single_fields price=%h qty=%h exp 00100 0064", cmd_r.price, cmd_r.quantity); end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL single_vld_clear got=%b exp=0", cmd_vld); end
  endtask

  task automatic test_stall;
    logic [111:0] fa, fb;
    logic [106:0] exp_b;
    fa = mk(32'd1, Op_SellLimit, 3'd1, 20'h12345, 16'h0010, 32'h0);
    fb = mk(32'd2, Op_Cancel, 3'd2, 20'h00ABC, 16'h0020, 32'h5);
    exp_b = fb[106:0];
    cmd_accept = 1'b0;
    send_frame(fa, 14);
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, i == 0, fb[111-8*i -: 8]);
      @(negedge clk);
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_b_rdy byte=%0d got=%b exp=1", i, in_rdy); end
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(1'b1, 1'b0, fb[7:0]);
      else begin @(posedge clk); #1; end
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy_low cyc=%0d got=%b exp=0", k, in_rdy); end
      checks++; if (cmd_vld !== 1'b1 || cmd_r.uid !== 32'd1) begin errors++; $display("FAIL stall_hold cyc=%0d vld=%b uid=%0d exp 1 1", k, cmd_vld, cmd_r.uid); end
    end
    @(posedge clk); #1 cmd_accept = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_accept got=%b exp=1", in_rdy); end
    @(posedge clk); #1 cmd_accept = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b1) begin errors++; $display("FAIL stall_no_bubble got=%b exp=1", cmd_vld); end
    checks++; if (cmd_r !== exp_b) begin errors++; $display("FAIL stall_cmd_b got=%h exp=%h", cmd_r, exp_b); end
    @(posedge clk); #1 cmd_accept = 1'b1;
    @(posedge clk); #1 cmd_accept = 1'b0;
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", cmd_vld); end
  endtask

  task automatic test_premature;
    logic [111:0] fj, fc;
    logic [106:0] exp_c;
    int d0, e0;
    fj = mk(32'd99, Op_BuyMarket, 3'd0, 20'h1, 16'h1, 32'h1);
    fc = mk(32'd3, Op_Modify, 3'd3, 20'hFFFFF, 16'hFFFF, 32'hCAFE);
    exp_c = fc[106:0];
    cmd_accept = 1'b1;
    @(posedge clk); d0 = deliv_n; e0 = ferr_n;
    send_frame(fj, 5);
    send_frame(fc, 14);
    idle(3);
    checks++; if (ferr_n - e0 !== 1) begin errors++; $display("FAIL premature_ferr got=%0d exp=1", ferr_n - e0); end
    checks++; if (deliv_n - d0 !== 1) begin errors++; $display("FAIL premature_deliv got=%0d exp=1", deliv_n - d0); end
    checks++; if (last_cmd !== exp_c) begin errors++; $display("FAIL premature_cmd got=%h exp=%h", last_cmd, exp_c); end
  endtask

  task automatic test_missing_sof;
    logic [111:0] f;
    logic [106:0] exp_c;
    int d0, e0;
    f = mk(32'd6, Op_Query, 3'd0, 20'h00777, 16'h0042, 32'h00000006);
    exp_c = f[106:0];
    cmd_accept = 1'b1;
    @(posedge clk); d0 = deliv_n; e0 = ferr_n;
    drive(1'b1, 1'b0, 8'hAB);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++; if (err_framing_r !== 1'b1) begin errors++; $display("FAIL missing_pulse got=%b exp=1", err_framing_r); end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++; if (err_framing_r !== 1'b0) begin errors++; $display("FAIL missing_pulse_end got=%b exp=0", err_framing_r); end
    send_frame(f, 14);
    idle(3);
    checks++; if (ferr_n - e0 !== 1) begin errors++; $display("FAIL missing_ferr got=%0d exp=1", ferr_n - e0); end
    checks++; if (deliv_n - d0 !== 1 || last_cmd !== exp_c) begin errors++; $display("FAIL missing_cmd n=%0d got=%h exp=%h", deliv_n - d0, last_cmd, exp_c); end
  endtask

  task automatic test_filter;
    logic [111:0] f1, f2;
    int d0, g0;
    f1 = mk(32'd5, 4'h7, 3'd0, 20'h10, 16'h10, 32'h0);
    f2 = mk(32'hFFFFFFFF, Op_BuyLimit, 3'd0, 20'h10, 16'h10, 32'h0);
    cmd_accept = 1'b1;
    @(posedge clk); d0 = deliv_n; g0 = filt_n;
    send_frame(f1, 14);
    send_frame(f2, 14);
    idle(3);
`ifdef OB_CMD_DES_FILTER_EN
    checks++; if (deliv_n - d0 !== 0) begin errors++; $display("FAIL filter_deliv got=%0d exp=0", deliv_n - d0); end
    checks++; if (filt_n - g0 !== 2) begin errors++; $display("FAIL filter_pulses got=%0d exp=2", filt_n - g0); end
`else
    checks++; if (deliv_n - d0 !== 2) begin errors++; $display("FAIL filter_deliv got=%0d exp=2", deliv_n - d0); end
    checks++; if (filt_n - g0 !== 0) begin errors++; $display("FAIL filter_pulses got=%0d exp=0", filt_n - g0); end
    checks++; if (last_cmd[106:75] !== 32'hFFFFFFFF) begin errors++; $display("FAIL filter_uid got=%h exp=ffffffff", last_cmd[106:75]); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [111:0] f1, f2;
    logic [106:0] exp2;
    int d0;
    f1 = mk(32'd8, Op_SellMarket, 3'd1, 20'h00200, 16'h0008, 32'h8);
    f2 = mk(32'd9, Op_Flush, 3'd2, 20'h00300, 16'h0009, 32'h9);
    exp2 = f2[106:0];
    cmd_accept = 1'b1;
    @(posedge clk); d0 = deliv_n;
    send_frame(f1, 14);
    send_frame(f2, 14);
    idle(3);
    checks++; if (deliv_n - d0 !== 2) begin errors++; $display("FAIL b2b_deliv got=%0d exp=2", deliv_n - d0); end
    checks++; if (last_cmd !== exp2) begin errors++; $display("FAIL b2b_cmd got=%h exp=%h", last_cmd, exp2); end
  endtask

  task automatic test_reset_mid;
    logic [111:0] fh, fp, f4;
    logic [106:0] exp4;
    int d0, e0, g0;
    fh = mk(32'd7, Op_BuyLimit, 3'd0, 20'h1, 16'h1, 32'h7);
    fp = mk(32'd77, Op_SellLimit, 3'd0, 20'h2, 16'h2, 32'h77);
    f4 = mk(32'd4, Op_Halt, 3'd3, 20'hABCDE, 16'h1234, 32'h89ABCDEF);
    exp4 = f4[106:0];
    cmd_accept = 1'b0;
    send_frame(fh, 14);
    send_frame(fp, 7);
    @(posedge clk); #1 in_vld = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_vld !== 1'b0 || cmd_r !== '0) begin errors++; $display("FAIL rstmid_state vld=%b cmd=%h exp 0 0", cmd_vld, cmd_r); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got=%b exp=1", in_rdy); end
    cmd_accept = 1'b1;
    @(posedge clk); d0 = deliv_n; e0 = ferr_n; g0 = filt_n;
    send_frame(f4, 14);
    idle(3);
    checks++; if (deliv_n - d0 !== 1 || last_cmd !== exp4) begin errors++; $display("FAIL rstmid_cmd n=%0d got=%h exp=%h", deliv_n - d0, last_cmd, exp4); end
    checks++; if (ferr_n - e0 !== 0 || filt_n - g0 !== 0) begin errors++; $display("FAIL rstmid_err ferr=%0d filt=%0d exp 0 0", ferr_n - e0, filt_n - g0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_premature;
    test_missing_sof;
    test_filter;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ob_cmd_des.md
# ob_cmd_des

Command ingress deserializer for the order-book matching engine. Accepts an 8-bit byte stream from the host interface, assembles 14-byte frames into `ob_pkg::cmd_t`, and presents one command at a time to the matching engine over a valid/accept handshake. Sits directly upstream of the engine's command port. It buffers one completed command while the next frame is being collected.

## Interface
- No parameters. Frame size is fixed by `ob_pkg::CMD_BYTES_N` (14).
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_vld` in 1: input byte valid.
- `in_sof` in 1: current byte is the first byte of a frame. Qualified by `in_vld`.
- `in_data` in 8: input byte.
- `in_rdy` out 1: byte accepted when `in_vld & in_rdy`.
- `cmd_vld` out 1: `cmd_r` holds a complete command.
- `cmd_r` out `$bits(ob_pkg::cmd_t)` (107): assembled command.
- `cmd_accept` in 1: consumer takes `cmd_r` this cycle. Ignored when `!cmd_vld`.
- `err_framing_r` out 1: one-cycle pulse when a frame is malformed.
- `err_filter_r` out 1: one-cycle pulse when a command is dropped. Present only with `OB_CMD_DES_FILTER_EN`; otherwise tied 0.

## Operation
- **Frame format.** 14 bytes form 112 bits, sent MSB-first (byte 0 = bits [111:104]).
  - Bits [106:0] map to `cmd_t` as packed: `uid`, `opcode`, `tif`, `price`, `quantity`, `uid1`.
  - Bits [111:107] are padding and are ignored.
- **Byte counter** `cnt_r`, 4 bits, range 0..13. It is the FSM state:
  - **IDLE:** `cnt_r == 0`.
  - **COLLECT:** `cnt_r` in 1..13.
- **Accepted byte with `cnt_r < 13`:**
  - The byte shifts into the 104-bit assembly register.
  - `cnt_r` increments.
- **Accepted byte with `cnt_r == 13`:**
  - The frame completes and is loaded into the output register.
  - `cmd_vld` sets and `cnt_r` returns to 0.
- **Framing check on the first byte:**
  - If `cnt_r == 0` and `in_sof == 0`, the byte is discarded, `err_framing_r` pulses, and `cnt_r` stays 0.
- **Framing check mid-frame:**
  - If `cnt_r != 0` and `in_sof == 1`, the partial frame is discarded and `err_framing_r` pulses.
  - This byte is taken as byte 0 of a new frame, so `cnt_r` becomes 1.
- **Output register.** Holds one command. `cmd_vld` clears on `cmd_accept` unless a new frame completes in the same cycle.
- **Back-pressure:**
  - `in_rdy = (cnt_r != 13) | !cmd_vld | cmd_accept`.
  - Bytes 0..12 of the next frame are always accepted.
  - Only the final byte stalls, and only while the output register is held.

## Timing
- **Latency.** Final byte accepted in cycle N gives `cmd_vld = 1` in cycle N+1.
- **Peak throughput.** One command per 14 cycles.
- **Handshake rules:**
  - `cmd_r` is stable while `cmd_vld & !cmd_accept`.
  - `in_rdy` depends combinationally on `cmd_accept`. There is no other combinational input-to-output path.
- **Final byte and `cmd_accept` in the same cycle.** The new command loads and `cmd_vld` stays 1 with no bubble.
- **Reset values** (after `rst_n == 0` at a clock edge):
  - `cnt_r = 0`, `cmd_vld = 0`, `cmd_r = '0`.
  - `err_framing_r = 0`, `err_filter_r = 0`.
  - `in_rdy = 1`.
- **Reset mid-frame.** The partial frame and any held command are lost. No error pulse.
- **Error pulses.** Registered; asserted for exactly the cycle after the offending byte.

## Configuration
- `OB_CMD_DES_FILTER_EN` defined:
  - A completed frame is dropped if any of the following holds:
    - `ob_pkg::opcode_is_legal(opcode)` is false (legal: 0x0–0x6, 0x8–0xB).
    - `uid == '1` (reserved for engine-initiated trades).
    - `tif > Tif_AllOrNone`.
  - A dropped frame is not loaded: `cmd_vld` is unchanged and `err_filter_r` pulses in cycle N+1.
  - Final-byte back-pressure still applies to dropped frames.
- `OB_CMD_DES_FILTER_EN` undefined:
  - Every completed frame is forwarded verbatim.
  - `err_filter_r` is constant 0.

## Structure
- Add to `ob_pkg`:
  - `localparam int CMD_BYTES_N = 14`.
  - `localparam int CMD_FRAME_W = CMD_BYTES_N * 8`.
  - `function automatic logic opcode_is_legal(opcode_t)`.
- Counter, assembly register and output register are all in `ob_cmd_des`.
- One sub-module is natural: `ob_cmd_filter`, a combinational validity check. It is instantiated only under `OB_CMD_DES_FILTER_EN`.

## Test plan
- **Single frame.** Send 14 bytes with `in_sof` on byte 0 encoding uid=0x00000010, op=Op_BuyLimit, tif=0, price=0x00100, qty=0x0064, uid1=0, with `cmd_accept` held 1.
  - Required: `cmd_vld` 1 for one cycle, 1 cycle after byte 13; `cmd_r` fields match exactly.
- **Stall and overlap.** Hold `cmd_accept = 0`, send frame A (uid=1) then frame B (uid=2).
  - Required: bytes 0..12 of B are accepted; `in_rdy = 0` at B byte 13; `cmd_r.uid` stays 1.
  - Then assert `cmd_accept` for one cycle. Required: B byte 13 is accepted that cycle and `cmd_r.uid = 2` next cycle, with `cmd_vld` never dropping.
- **Premature `in_sof`.** Send 5 bytes, then a new `in_sof` frame (uid=3).
  - Required: `err_framing_r` pulses once and only uid=3 is delivered.
- **Missing `in_sof`.** Send a byte with `in_sof = 0` while idle.
  - Required: the byte is dropped, `err_framing_r` pulses, `cnt_r` stays 0.
- **Filter.** Send a frame with opcode 0x7, then one with uid=0xFFFFFFFF.
  - With `OB_CMD_DES_FILTER_EN`: both are dropped with two `err_filter_r` pulses and no `cmd_vld`.
  - Without it: both are delivered.
- **Reset mid-frame.** Drive `rst_n = 0` after 7 bytes, then send a full frame (uid=4).
  - Required: uid=4 is delivered intact and there are no error pulses.
